// File: rtl/gpu_pkg.sv
// Shared types, default sizes and the cyclic next-active-warp search used by
// the warp sequencer and its round-robin arbiter.
package gpu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } seq_state_t;

   localparam int NUM_WARPS_DEF = 4;
   localparam int PC_WIDTH_DEF  = 4;
   localparam int MAX_WARPS     = 32;

   // Returns the first set bit strictly after ptr, wrapping at n; ptr itself is
   // reached last, and ptr is returned unchanged when the mask is empty.
   function automatic int next_active(input logic [MAX_WARPS-1:0] mask,
                                      input int ptr,
                                      input int n = NUM_WARPS_DEF);
      int idx;
      next_active = ptr;
      for (int i = MAX_WARPS; i >= 1; i--) begin
         if (i <= n) begin
            idx = (ptr + i) % n;
            if (mask[idx]) next_active = idx;
         end
      end
   endfunction

endpackage

// File: rtl/gpu_rr_arbiter.sv
// Combinational round-robin selector: next set bit of mask after ptr (cyclic),
// plus a flag telling whether any bit is set at all.
module gpu_rr_arbiter
   import gpu_pkg::*;
#(
   parameter int N = NUM_WARPS_DEF,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] mask,
   input  logic [W-1:0] ptr,
   output logic [W-1:0] next_idx,
   output logic         any
);

   always_comb begin
      next_idx = W'(next_active(MAX_WARPS'(mask), int'(ptr), N));
      any      = |mask;
   end

endmodule

// File: rtl/gpu_warp_sequencer.sv
// Multi-warp program sequencer issuing (warp, pc) pairs round-robin.
// Define GPU_SEQ_PERF_EN to add the issue_count handshake counter output.
module gpu_warp_sequencer
   import gpu_pkg::*;
#(
   parameter  int NUM_WARPS = NUM_WARPS_DEF,
   parameter  int PC_WIDTH  = PC_WIDTH_DEF,
   localparam int WID_W     = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [PC_WIDTH-1:0]  base_pc,
   input  logic [PC_WIDTH-1:0]  end_pc,
   input  logic [NUM_WARPS-1:0] warp_mask,
   output logic                 issue_valid,
   input  logic                 issue_ready,
   output logic [WID_W-1:0]     issue_warp,
   output logic [PC_WIDTH-1:0]  issue_pc,
   output logic [NUM_WARPS-1:0] warp_exit,
`ifdef GPU_SEQ_PERF_EN
   output logic [15:0]          issue_count,
`endif
   output logic                 busy,
   output logic                 done
);

   seq_state_t           state_q, state_d;
   logic [PC_WIDTH-1:0]  pc_q [NUM_WARPS];
   logic [PC_WIDTH-1:0]  pc_d [NUM_WARPS];
   logic [PC_WIDTH-1:0]  end_pc_q, end_pc_d;
   logic [NUM_WARPS-1:0] active_q, active_d, active_post;
   logic [NUM_WARPS-1:0] warp_exit_q, warp_exit_d;
   logic [WID_W-1:0]     ptr_q, ptr_d;
   logic [WID_W-1:0]     rr_next, first_idx;
   logic                 rr_any, first_any;
   logic                 handshake, at_end;
`ifdef GPU_SEQ_PERF_EN
   logic [15:0]          count_q, count_d;
`endif

   // Next warp after ptr, judged on the mask as it stands after this retirement.
   gpu_rr_arbiter #(.N(NUM_WARPS), .W(WID_W)) u_rr (
      .mask     (active_post),
      .ptr      (ptr_q),
      .next_idx (rr_next),
      .any      (rr_any)
   );

   // Searching after the top index yields the lowest set bit of the launch mask.
   gpu_rr_arbiter #(.N(NUM_WARPS), .W(WID_W)) u_first (
      .mask     (warp_mask),
      .ptr      (WID_W'(NUM_WARPS - 1)),
      .next_idx (first_idx),
      .any      (first_any)
   );

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      end_pc_d    = end_pc_q;
      active_d    = active_q;
      warp_exit_d = warp_exit_q;
      ptr_d       = ptr_q;
`ifdef GPU_SEQ_PERF_EN
      count_d     = count_q;
`endif
      handshake   = (state_q == RUN) && issue_ready;
      at_end      = (pc_q[ptr_q] == end_pc_q);
      active_post = active_q;
      if (handshake && at_end) active_post[ptr_q] = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               for (int i = 0; i < NUM_WARPS; i++) pc_d[i] = base_pc;
               end_pc_d    = end_pc;
               active_d    = warp_mask;
               warp_exit_d = '0;
               ptr_d       = first_idx;
`ifdef GPU_SEQ_PERF_EN
               count_d     = '0;
`endif
               if (!first_any || (base_pc > end_pc)) begin
                  state_d     = DONE;
                  warp_exit_d = warp_mask;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (handshake) begin
               active_d = active_post;
`ifdef GPU_SEQ_PERF_EN
               if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
`endif
               if (at_end) warp_exit_d[ptr_q] = 1'b1;
               else        pc_d[ptr_q] = pc_q[ptr_q] + PC_WIDTH'(1);
               if (rr_any) ptr_d = rr_next;
               else        state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         end_pc_q    <= '0;
         active_q    <= '0;
         warp_exit_q <= '0;
         ptr_q       <= '0;
`ifdef GPU_SEQ_PERF_EN
         count_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         end_pc_q    <= end_pc_d;
         active_q    <= active_d;
         warp_exit_q <= warp_exit_d;
         ptr_q       <= ptr_d;
`ifdef GPU_SEQ_PERF_EN
         count_q     <= count_d;
`endif
      end
   end

   for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_pc
      always_ff @(posedge clk) begin
         if (rst) pc_q[gi] <= '0;
         else     pc_q[gi] <= pc_d[gi];
      end
   end

   // Issue payload comes straight from state registers so it cannot glitch during a stall.
   assign issue_valid = (state_q == RUN);
   assign issue_warp  = ptr_q;
   assign issue_pc    = pc_q[ptr_q];
   assign warp_exit   = warp_exit_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
`ifdef GPU_SEQ_PERF_EN
   assign issue_count = count_q;
`endif

endmodule

// File: tb/tb_gpu_warp_sequencer.sv
// Directed self-checking bench for gpu_warp_sequencer (4 warps, 4-bit PC).
module tb_gpu_warp_sequencer;

   logic       clk = 1'b0;
   logic       rst, start, issue_ready;
   logic [3:0] base_pc, end_pc, warp_mask;
   logic       issue_valid;
   logic [1:0] issue_warp;
   logic [3:0] issue_pc, warp_exit;
   logic       busy, done;
`ifdef GPU_SEQ_PERF_EN
   logic [15:0] issue_count;
`endif

   int checks = 0;
   int errors = 0;

   int cap_n, first_valid_k, last_hs_k, done_k, stall_viol;
   int cap_w [64];
   int cap_pc [64];
   bit timed_out;

   gpu_warp_sequencer #(.NUM_WARPS(4), .PC_WIDTH(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .base_pc     (base_pc),
      .end_pc      (end_pc),
      .warp_mask   (warp_mask),
      .issue_valid (issue_valid),
      .issue_ready (issue_ready),
      .issue_warp  (issue_warp),
      .issue_pc    (issue_pc),
      .warp_exit   (warp_exit),
`ifdef GPU_SEQ_PERF_EN
      .issue_count (issue_count),
`endif
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic launch(input logic [3:0] b, input logic [3:0] e, input logic [3:0] m);
      @(negedge clk);
      base_pc   = b;
      end_pc    = e;
      warp_mask = m;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
   endtask

   // Drives ready (mode 0: always 1, mode 1: 1,0,0,1 repeating) and records
   // every handshake until done is seen or the cycle budget runs out.
   task automatic collect(input int mode, input int max_k);
      logic       pv, pr;
      logic [1:0] pw;
      logic [3:0] pp;
      cap_n = 0; first_valid_k = -1; last_hs_k = -1; done_k = -1;
      stall_viol = 0; timed_out = 1'b0;
      pv = 1'b0; pr = 1'b1; pw = '0; pp = '0;
      for (int k = 0; k < max_k; k++) begin
         if (k > 0) @(negedge clk);
         issue_ready = (mode == 0) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
         if (pv && !pr && (!issue_valid || issue_warp !== pw || issue_pc !== pp))
            stall_viol++;
         if (issue_valid && first_valid_k < 0) first_valid_k = k;
         if (issue_valid && issue_ready && cap_n < 64) begin
            cap_w[cap_n]  = int'(issue_warp);
            cap_pc[cap_n] = int'(issue_pc);
            $display("issue %0d: warp %0d pc %0d (cycle %0d)", cap_n, issue_warp, issue_pc, k);
            cap_n++;
            last_hs_k = k;
         end
         if (done) begin
            done_k = k;
            break;
         end
         pv = issue_valid; pr = issue_ready; pw = issue_warp; pp = issue_pc;
      end
      if (done_k < 0) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; issue_ready = 1'b0;
      base_pc = '0; end_pc = '0; warp_mask = '0;
      repeat (3) @(negedge clk);
      checks++;
      if ({issue_valid, issue_warp, issue_pc, warp_exit, busy, done} !== 13'd0) begin
         errors++;
         $display("FAIL reset_outputs got v=%0b w=%0d pc=%0d exit=%b busy=%0b done=%0b want all 0",
                  issue_valid, issue_warp, issue_pc, warp_exit, busy, done);
      end
`ifdef GPU_SEQ_PERF_EN
      checks++;
      if (issue_count !== 16'd0) begin
         errors++;
         $display("FAIL reset_count got %0d want 0", issue_count);
      end
`endif
      rst = 1'b0;
   endtask

   task automatic test_basic();
      int exp_w  [6] = '{0, 1, 0, 1, 0, 1};
      int exp_pc [6] = '{2, 2, 3, 3, 4, 4};
      launch(4'd2, 4'd4, 4'b0011);
      collect(0, 40);
      checks++;
      if (timed_out) begin errors++; $display("FAIL basic_timeout got no done want done"); end
      checks++;
      if (cap_n != 6) begin errors++; $display("FAIL basic_count got %0d want 6", cap_n); end
      for (int i = 0; i < 6 && i < cap_n; i++) begin
         checks++;
         if (cap_w[i] != exp_w[i] || cap_pc[i] != exp_pc[i]) begin
            errors++;
            $display("FAIL basic_issue%0d got (%0d,%0d) want (%0d,%0d)",
                     i, cap_w[i], cap_pc[i], exp_w[i], exp_pc[i]);
         end
      end
      checks++;
      if (first_valid_k != 0) begin errors++; $display("FAIL basic_first_valid got cycle %0d want 0", first_valid_k); end
      checks++;
      if (done_k != last_hs_k + 1) begin
         errors++; $display("FAIL basic_done_latency got cycle %0d want %0d", done_k, last_hs_k + 1);
      end
      checks++;
      if (warp_exit !== 4'b0011) begin errors++; $display("FAIL basic_exit got %b want 0011", warp_exit); end
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || warp_exit !== 4'b0011) begin
         errors++;
         $display("FAIL basic_after_done got done=%0b busy=%0b exit=%b want 0 0 0011", done, busy, warp_exit);
      end
`ifdef GPU_SEQ_PERF_EN
      checks++;
      if (issue_count !== 16'd6) begin errors++; $display("FAIL perf_count got %0d want 6", issue_count); end
`endif
   endtask

   task automatic test_backpressure();
      int exp_w  [6] = '{0, 1, 0, 1, 0, 1};
      int exp_pc [6] = '{2, 2, 3, 3, 4, 4};
      launch(4'd2, 4'd4, 4'b0011);
`ifdef GPU_SEQ_PERF_EN
      checks++;
      if (issue_count !== 16'd0) begin errors++; $display("FAIL perf_clear got %0d want 0", issue_count); end
`endif
      collect(1, 60);
      checks++;
      if (timed_out) begin errors++; $display("FAIL bp_timeout got no done want done"); end
      checks++;
      if (stall_viol != 0) begin errors++; $display("FAIL bp_stall_stable got %0d changes want 0", stall_viol); end
      checks++;
      if (cap_n != 6) begin errors++; $display("FAIL bp_count got %0d want 6", cap_n); end
      for (int i = 0; i < 6 && i < cap_n; i++) begin
         checks++;
         if (cap_w[i] != exp_w[i] || cap_pc[i] != exp_pc[i]) begin
            errors++;
            $display("FAIL bp_issue%0d got (%0d,%0d) want (%0d,%0d)",
                     i, cap_w[i], cap_pc[i], exp_w[i], exp_pc[i]);
         end
      end
      checks++;
      if (done_k != 12) begin errors++; $display("FAIL bp_done_cycle got %0d want 12", done_k); end
   endtask

   task automatic test_sparse();
      launch(4'd7, 4'd7, 4'b1010);
      collect(0, 20);
      checks++;
      if (cap_n != 2) begin errors++; $display("FAIL sparse_count got %0d want 2", cap_n); end
      checks++;
      if (cap_n >= 2 && (cap_w[0] != 1 || cap_pc[0] != 7 || cap_w[1] != 3 || cap_pc[1] != 7)) begin
         errors++;
         $display("FAIL sparse_order got (%0d,%0d),(%0d,%0d) want (1,7),(3,7)",
                  cap_w[0], cap_pc[0], cap_w[1], cap_pc[1]);
      end
      checks++;
      if (done_k != 2) begin errors++; $display("FAIL sparse_done got cycle %0d want 2", done_k); end
      checks++;
      if (warp_exit !== 4'b1010) begin errors++; $display("FAIL sparse_exit got %b want 1010", warp_exit); end
   endtask

   task automatic test_degenerate();
      launch(4'd2, 4'd4, 4'b0000);
      collect(0, 10);
      checks++;
      if (cap_n != 0 || first_valid_k != -1 || done_k != 0) begin
         errors++;
         $display("FAIL empty_mask got issues=%0d valid_at=%0d done_at=%0d want 0 -1 0",
                  cap_n, first_valid_k, done_k);
      end
      checks++;
      if (warp_exit !== 4'b0000) begin errors++; $display("FAIL empty_mask_exit got %b want 0000", warp_exit); end
      launch(4'd5, 4'd3, 4'b1111);
      collect(0, 10);
      checks++;
      if (cap_n != 0 || first_valid_k != -1 || done_k != 0) begin
         errors++;
         $display("FAIL inverted_range got issues=%0d valid_at=%0d done_at=%0d want 0 -1 0",
                  cap_n, first_valid_k, done_k);
      end
      checks++;
      if (warp_exit !== 4'b1111) begin errors++; $display("FAIL inverted_exit got %b want 1111", warp_exit); end
   endtask

   task automatic test_midrun();
      launch(4'd0, 4'd9, 4'b1111);
      issue_ready = 1'b1;
      base_pc = 4'd3; end_pc = 4'd3; warp_mask = 4'b0001; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (issue_valid !== 1'b1 || issue_warp !== 2'd1 || issue_pc !== 4'd0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL ignored_start got v=%0b w=%0d pc=%0d busy=%0b want 1 1 0 1",
                  issue_valid, issue_warp, issue_pc, busy);
      end
      issue_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({issue_valid, issue_warp, issue_pc, warp_exit, busy, done} !== 13'd0) begin
         errors++;
         $display("FAIL midrun_reset got v=%0b w=%0d pc=%0d exit=%b busy=%0b done=%0b want all 0",
                  issue_valid, issue_warp, issue_pc, warp_exit, busy, done);
      end
      launch(4'd15, 4'd15, 4'b0001);
      collect(0, 10);
      checks++;
      if (cap_n != 1 || (cap_n >= 1 && (cap_w[0] != 0 || cap_pc[0] != 15))) begin
         errors++;
         $display("FAIL top_pc got %0d issues first (%0d,%0d) want 1 issue (0,15)",
                  cap_n, cap_w[0], cap_pc[0]);
      end
      checks++;
      if (done_k != 1 || warp_exit !== 4'b0001) begin
         errors++;
         $display("FAIL top_pc_done got done_at=%0d exit=%b want 1 0001", done_k, warp_exit);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (issue_valid !== 1'b0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL top_pc_nowrap got v=%0b busy=%0b want 0 0", issue_valid, busy);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_sparse();
      test_degenerate();
      test_midrun();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
